// File: rtl/clk_sup_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_sup_pkg
// Purpose  : Shared constants for the PLL clock supervisor: supervisor state
//            encoding and a helper that sizes counters from their maximum value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clk_sup_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_ST_WAIT_LOCK = 2'd0;
  localparam state_t c_ST_PLL_RST   = 2'd1;
  localparam state_t c_ST_RELEASE   = 2'd2;
  localparam state_t c_ST_RUN       = 2'd3;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ce_divider.sv
`default_nettype none
// ============================================================================
// Module   : ce_divider
// Purpose  : Per-channel clock-enable generator. Emits a one-cycle pulse every
//            i_div+1 cycles once the channel is out of reset; the first pulse
//            lands i_div cycles after the release edge.
// Ports    : clk, rst_n, i_en_nxt (channel reset-release value for next cycle),
//            i_en (current channel reset-release value), i_div (divide
//            setting), o_ce (registered enable pulse)
// Revision : 1.0 - initial release
// ============================================================================
module ce_divider #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en_nxt,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_ce
);

  // r_cnt holds the number of cycles still to wait before the next pulse.
  logic [DIV_W-1:0] r_cnt;
  logic             r_ce;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else if (!i_en_nxt) begin
      // Looking at the next-cycle enable keeps ce low in exactly the cycles
      // where the channel reset is asserted.
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else if (!i_en) begin
      // Release edge: a divide of zero pulses immediately, otherwise the
      // first pulse is i_div cycles away.
      r_ce  <= (i_div == '0);
      r_cnt <= (i_div == '0) ? '0 : i_div - 1'b1;
    end else if (r_cnt == '0) begin
      // Pulse and reload; i_div is only looked at here and at release.
      r_ce  <= 1'b1;
      r_cnt <= i_div;
    end else begin
      r_ce  <= 1'b0;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_ce = r_ce;

endmodule
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser bringing an asynchronous level into clk.
// Ports    : clk, rst_n (async active-low), i_d (async level), o_q (synced)
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_clk_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_clk_supervisor
// Purpose  : Supervises a PLL: filters its lock flag, resets the PLL on lock
//            timeout, releases per-channel resets in a staggered sequence,
//            generates per-channel clock enables and records lock losses.
// Ports    : clk, rst_n           - reference clock, async active-low reset
//            i_pll_lock           - PLL lock flag (asynchronous)
//            i_div_cfg            - per-channel divide settings
//            i_clr_status         - clears o_lock_lost and o_relock_cnt
//            o_pll_reset          - active-high PLL reset request
//            o_rst_out_n          - per-channel active-low resets
//            o_ce                 - per-channel clock-enable pulses
//            o_locked             - supervisor in RUN
//            o_lock_lost          - sticky lock-loss flag
//            o_relock_cnt         - saturating lock-loss counter
// Revision : 1.0 - initial release
// ============================================================================
module pll_clk_supervisor
  import clk_sup_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned FILT_LEN    = 16,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned PLL_RST_LEN = 16,
  parameter int unsigned STAGGER     = 8,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_pll_lock,
  input  logic [N_CH*DIV_W-1:0]   i_div_cfg,
  input  logic                    i_clr_status,
  output logic                    o_pll_reset,
  output logic [N_CH-1:0]         o_rst_out_n,
  output logic [N_CH-1:0]         o_ce,
  output logic                    o_locked,
  output logic                    o_lock_lost,
  output logic [CNT_W-1:0]        o_relock_cnt
);

  localparam int unsigned FILT_W = cnt_width(FILT_LEN);
  localparam int unsigned TO_W   = cnt_width(TIMEOUT);
  localparam int unsigned PRST_W = cnt_width(PLL_RST_LEN);
  localparam int unsigned REL_W  = cnt_width(STAGGER * N_CH);

  // Counters compare against their last value so they never need a wider
  // bit to represent the terminal count.
  localparam logic [FILT_W-1:0] c_FILT_LAST = FILT_W'(FILT_LEN - 1);
  localparam logic [TO_W-1:0]   c_TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [PRST_W-1:0] c_PRST_LAST = PRST_W'(PLL_RST_LEN - 1);
  localparam logic [REL_W-1:0]  c_REL_DONE  = REL_W'(STAGGER * N_CH);

  logic              w_lock_s;
  state_t            r_state, w_state_nxt;
  logic [FILT_W-1:0] r_filt_cnt, w_filt_nxt;
  logic [TO_W-1:0]   r_to_cnt, w_to_nxt;
  logic [PRST_W-1:0] r_prst_cnt, w_prst_nxt;
  logic [REL_W-1:0]  r_rel_cnt, w_rel_nxt;
  logic              w_loss;
  logic [N_CH-1:0]   w_rel_hit;

  logic              r_pll_reset, w_pll_reset_nxt;
  logic [N_CH-1:0]   r_rst_out_n, w_rst_out_n_nxt;
  logic              r_locked, w_locked_nxt;
  logic              r_lock_lost, w_lock_lost_nxt;
  logic [CNT_W-1:0]  r_relock_cnt, w_relock_nxt;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_pll_lock),
    .o_q   (w_lock_s)
  );

  // State and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_WAIT_LOCK;
      r_filt_cnt <= '0;
      r_to_cnt   <= '0;
      r_prst_cnt <= '0;
      r_rel_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_filt_cnt <= w_filt_nxt;
      r_to_cnt   <= w_to_nxt;
      r_prst_cnt <= w_prst_nxt;
      r_rel_cnt  <= w_rel_nxt;
    end
  end

  // Next-state logic. Counters default to zero so every state entry starts
  // from a clean count.
  always_comb begin
    w_state_nxt = r_state;
    w_filt_nxt  = '0;
    w_to_nxt    = '0;
    w_prst_nxt  = '0;
    w_rel_nxt   = '0;
    w_loss      = 1'b0;
    case (r_state)
      c_ST_WAIT_LOCK: begin
        // Filter completion is tested first so it beats a same-cycle timeout.
        if (w_lock_s && (r_filt_cnt == c_FILT_LAST)) begin
          w_state_nxt = c_ST_RELEASE;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_state_nxt = c_ST_PLL_RST;
        end else begin
          w_filt_nxt = w_lock_s ? r_filt_cnt + 1'b1 : '0;
          w_to_nxt   = r_to_cnt + 1'b1;
        end
      end
      c_ST_PLL_RST: begin
        if (r_prst_cnt == c_PRST_LAST) begin
          w_state_nxt = c_ST_WAIT_LOCK;
        end else begin
          w_prst_nxt = r_prst_cnt + 1'b1;
        end
      end
      c_ST_RELEASE: begin
        if (!w_lock_s) begin
          w_loss      = 1'b1;
          w_state_nxt = c_ST_WAIT_LOCK;
        end else if (r_rel_cnt == c_REL_DONE) begin
          w_state_nxt = c_ST_RUN;
        end else begin
          w_rel_nxt = r_rel_cnt + 1'b1;
        end
      end
      c_ST_RUN: begin
        if (!w_lock_s) begin
          w_loss      = 1'b1;
          w_state_nxt = c_ST_WAIT_LOCK;
        end
      end
      default: w_state_nxt = c_ST_WAIT_LOCK;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_pll_reset_nxt = (w_state_nxt == c_ST_PLL_RST);
    w_locked_nxt    = (w_state_nxt == c_ST_RUN);
    w_rst_out_n_nxt = '0;
    if (!w_loss && ((r_state == c_ST_RELEASE) || (r_state == c_ST_RUN))) begin
      w_rst_out_n_nxt = r_rst_out_n | w_rel_hit;
    end
    w_lock_lost_nxt = r_lock_lost;
    w_relock_nxt    = r_relock_cnt;
    if (w_loss) begin
      // A loss in the same cycle as a clear still records that loss.
      w_lock_lost_nxt = 1'b1;
      if (i_clr_status) begin
        w_relock_nxt = CNT_W'(1);
      end else if (!(&r_relock_cnt)) begin
        w_relock_nxt = r_relock_cnt + 1'b1;
      end
    end else if (i_clr_status) begin
      w_lock_lost_nxt = 1'b0;
      w_relock_nxt    = '0;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_reset  <= 1'b0;
      r_rst_out_n  <= '0;
      r_locked     <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_relock_cnt <= '0;
    end else begin
      r_pll_reset  <= w_pll_reset_nxt;
      r_rst_out_n  <= w_rst_out_n_nxt;
      r_locked     <= w_locked_nxt;
      r_lock_lost  <= w_lock_lost_nxt;
      r_relock_cnt <= w_relock_nxt;
    end
  end

  // Channel k leaves reset on the STAGGER*(k+1)-th cycle spent in RELEASE.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_rel_hit[k] = (r_rel_cnt == REL_W'(STAGGER * (k + 1) - 1));

    ce_divider #(
      .DIV_W (DIV_W)
    ) u_ce_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en_nxt (w_rst_out_n_nxt[k]),
      .i_en     (r_rst_out_n[k]),
      .i_div    (i_div_cfg[k*DIV_W +: DIV_W]),
      .o_ce     (o_ce[k])
    );
  end

  assign o_pll_reset  = r_pll_reset;
  assign o_rst_out_n  = r_rst_out_n;
  assign o_locked     = r_locked;
  assign o_lock_lost  = r_lock_lost;
  assign o_relock_cnt = r_relock_cnt;

endmodule
`default_nettype wire
